multi_line_window_buffer: RTL and testbench

- Parametrised successor to the single-line 3-tap line buffer.
- Holds NUM_LINES image rows in a circular bank and presents a full KERNEL x KERNEL pixel window per read, so a convolution stage (Sobel/Gaussian) needs no external row stacking.
- Adds ready/valid flow control, line-complete accounting and an optional right-edge replicate mode.
- Sits between the pixel stream source and the convolution/gradient stage.

---
 rtl/multi_line_window_buffer.sv | 114 +++++++++++
 tb/tb_multi_line_window_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_line_window_buffer.sv
// Circular multi-row line buffer presenting a KERNEL x KERNEL pixel window with ready/valid flow control.
// Optional right-edge replication of the window is enabled by defining LB_BORDER_REPLICATE_EN.
module multi_line_window_buffer #(
    parameter int DATA_W      = 8,
    parameter int IMAGE_WIDTH = 512,
    parameter int KERNEL      = 3,
    parameter int NUM_LINES   = KERNEL + 1
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic                              i_data_valid,
    output logic                              i_ready,
    input  logic                              rd_enable,
    output logic                              o_valid,
    output logic [KERNEL*KERNEL*DATA_W-1:0]   o_data,
    output logic                              o_last_col
);

    localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(NUM_LINES + 1);
`ifdef LB_BORDER_REPLICATE_EN
    localparam int LAST_COL = IMAGE_WIDTH - 1;
`else
    localparam int LAST_COL = IMAGE_WIDTH - KERNEL;
`endif

    logic [DATA_W-1:0] mem [NUM_LINES][IMAGE_WIDTH];

    logic [COL_W-1:0]  wr_col;
    logic [COL_W-1:0]  rd_col;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_line;
    logic [CNT_W-1:0]  full_lines;

    logic wr_acc;
    logic rd_acc;
    logic line_done_wr;
    logic line_done_rd;

    function automatic logic [LINE_W-1:0] line_add(input logic [LINE_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_LINES) s = s - NUM_LINES;
        return LINE_W'(s);
    endfunction

    function automatic logic [COL_W-1:0] tap_col(input logic [COL_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
`ifdef LB_BORDER_REPLICATE_EN
        if (s > IMAGE_WIDTH - 1) s = IMAGE_WIDTH - 1;
`endif
        return COL_W'(s);
    endfunction

    assign i_ready      = (full_lines < CNT_W'(NUM_LINES));
    assign o_valid      = (full_lines >= CNT_W'(KERNEL));
    assign o_last_col   = o_valid && (rd_col == COL_W'(LAST_COL));
    assign wr_acc       = i_data_valid && i_ready;
    assign rd_acc       = rd_enable && o_valid;
    assign line_done_wr = wr_acc && (wr_col == COL_W'(IMAGE_WIDTH - 1));
    assign line_done_rd = rd_acc && (rd_col == COL_W'(LAST_COL));

    // Pixel storage is never reset; only fully written lines are ever exposed.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_line][wr_col] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_col     <= '0;
            wr_line    <= '0;
            rd_col     <= '0;
            rd_line    <= '0;
            full_lines <= '0;
        end else begin
            if (wr_acc) begin
                if (line_done_wr) begin
                    wr_col  <= '0;
                    wr_line <= line_add(wr_line, 1);
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end
            if (rd_acc) begin
                if (line_done_rd) begin
                    rd_col  <= '0;
                    rd_line <= line_add(rd_line, 1);
                end else begin
                    rd_col <= rd_col + COL_W'(1);
                end
            end
            case ({line_done_wr, line_done_rd})
                2'b10:   full_lines <= full_lines + CNT_W'(1);
                2'b01:   full_lines <= full_lines - CNT_W'(1);
                default: full_lines <= full_lines;
            endcase
        end
    end

    // Window view: row 0 is the oldest line, column 0 lands in the MSBs.
    always_comb begin
        o_data = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                o_data[(KERNEL*KERNEL-1-(r*KERNEL+c))*DATA_W +: DATA_W] =
                    mem[line_add(rd_line, r)][tap_col(rd_col, c)];
            end
        end
    end

endmodule

// File: tb/tb_multi_line_window_buffer.sv
// Scoreboard bench for multi_line_window_buffer: a line-queue reference model predicts every cycle,
// a separate monitor compares the DUT outputs against the queued predictions.
module tb_multi_line_window_buffer;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int K  = 3;
    localparam int NL = 4;
    localparam int KK = K * K;
`ifdef LB_BORDER_REPLICATE_EN
    localparam int LAST = IW - 1;
`else
    localparam int LAST = IW - K;
`endif

    typedef logic [IW*DW-1:0] line_t;
    typedef logic [KK*DW-1:0] win_t;
    typedef struct {
        bit   rdy;
        bit   vld;
        bit   last;
        win_t win;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          i_ready;
    logic          rd_enable;
    logic          o_valid;
    win_t          o_data;
    logic          o_last_col;

    always #5 clk = ~clk;

    multi_line_window_buffer #(
        .DATA_W(DW), .IMAGE_WIDTH(IW), .KERNEL(K), .NUM_LINES(NL)
    ) dut (
        .clk(clk), .rstN(rstN), .i_data(i_data), .i_data_valid(i_data_valid),
        .i_ready(i_ready), .rd_enable(rd_enable), .o_valid(o_valid),
        .o_data(o_data), .o_last_col(o_last_col)
    );

    // Reference model: queue of completed rows, the row being written, and the read column.
    line_t lines[$];
    line_t cur;
    int    cur_n;
    int    rcol;
    bit    started;
    exp_t  exp_q[$];
    int    n_checks;
    int    n_fail;

    function automatic win_t model_window();
        win_t  w;
        line_t ln;
        int    col;
        w = '0;
        for (int r = 0; r < K; r++) begin
            ln = lines[r];
            for (int c = 0; c < K; c++) begin
                col = rcol + c;
                if (col > IW - 1) col = IW - 1;
                w[(KK-1-(r*K+c))*DW +: DW] = ln[col*DW +: DW];
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input win_t act, input win_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit rd, input bit rn);
        exp_t e;
        bit   rd_acc;
        bit   wr_acc;
        i_data_valid = v;
        i_data       = d;
        rd_enable    = rd;
        rstN         = rn;
        if (started) begin
            e.rdy  = lines.size() < NL;
            e.vld  = lines.size() >= K;
            e.last = e.vld && (rcol == LAST);
            e.win  = e.vld ? model_window() : '0;
            exp_q.push_back(e);
        end
        if (!rn) begin
            lines.delete();
            cur_n   = 0;
            rcol    = 0;
            started = 1'b1;
        end else begin
            rd_acc = rd && (lines.size() >= K);
            wr_acc = v && (lines.size() < NL);
            if (rd_acc) begin
                if (rcol == LAST) begin
                    void'(lines.pop_front());
                    rcol = 0;
                end else begin
                    rcol++;
                end
            end
            if (wr_acc) begin
                cur[cur_n*DW +: DW] = d;
                cur_n++;
                if (cur_n == IW) begin
                    lines.push_back(cur);
                    cur_n = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_lines(input int first, input int count);
        for (int l = first; l < first + count; l++)
            for (int c = 0; c < IW; c++)
                step(1'b1, 8'(l * 16 + c), 1'b0, 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("i_ready", win_t'(i_ready), win_t'(e.rdy));
                check("o_valid", win_t'(o_valid), win_t'(e.vld));
                check("o_last_col", win_t'(o_last_col), win_t'(e.last));
                if (e.vld) check("o_data", o_data, e.win);
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        started      = 1'b0;
        cur          = '0;
        cur_n        = 0;
        rcol         = 0;
        rstN         = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        rd_enable    = 1'b0;
        @(posedge clk);
        #1;

        step(1'b0, 8'h00, 1'b0, 1'b0);
        write_lines(0, 3);
        check("fill_valid", win_t'(o_valid), win_t'(1));
        check("fill_window", o_data, 72'h000102_101112_202122);
        repeat (LAST + 1) step(1'b0, 8'h00, 1'b1, 1'b1);
        check("sweep_valid_low", win_t'(o_valid), win_t'(0));

        step(1'b0, 8'h00, 1'b0, 1'b0);
        write_lines(0, 4);
        check("bp_ready_low", win_t'(i_ready), win_t'(0));
        step(1'b1, 8'h99, 1'b0, 1'b1);
        repeat (2 * (LAST + 1)) step(1'b0, 8'h00, 1'b1, 1'b1);
        write_lines(4, 1);
        repeat (LAST + 1) step(1'b0, 8'h00, 1'b1, 1'b1);

        step(1'b0, 8'h00, 1'b0, 1'b0);
        write_lines(0, 3);
        for (int c = 0; c < IW; c++)
            step(1'b1, 8'(8'h30 + c), (c >= IW - (LAST + 1)), 1'b1);
        check("simul_valid", win_t'(o_valid), win_t'(1));
        check("simul_window", o_data, 72'h101112_202122_303132);
        repeat (LAST + 1) step(1'b0, 8'h00, 1'b1, 1'b1);

        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 13; c++) step(1'b1, 8'(c), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_ready", win_t'(i_ready), win_t'(1));
        check("rst_valid", win_t'(o_valid), win_t'(0));
        write_lines(0, 3);
        check("refill_window", o_data, 72'h000102_101112_202122);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0)
                step(1'b0, 8'h00, 1'b0, 1'b0);
            else
                step(($urandom % 4) != 0, 8'($urandom),
                     ($urandom % 8) < (((i / 400) % 2 == 1) ? 7 : 2), 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", win_t'(exp_q.size()), win_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
